// File: rtl/wash_cycle_timer.sv
// -----------------------------------------------------------------------------
// wash_cycle_timer
//
// Purpose:
//   Per-phase countdown timer for a washing-machine sequencer. A 16-entry
//   duration table indexed by {mode, phase_sel} supplies the length of each
//   phase in time units; a prescaler divides clk by TICK_DIV to form the time
//   unit. The sequencer raises timer_enable, selects a phase, and receives a
//   one-cycle timer_done pulse when the programmed duration has elapsed.
//
// Parameters:
//   TICK_DIV    clk cycles per time unit (>= 2)
//   CNT_W       width of durations and of the remaining count
//   DEFAULT_DUR reset value of every duration-table entry
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   timer_enable  phase timing requested
//   phase_sel     active phase: 0 soak, 1 wash, 2 rinse, 3 spin
//   mode          program profile 0..3
//   pause         freeze the countdown (lid open / power hold)
//   cfg_we        duration-table write strobe
//   cfg_addr      table index {mode, phase}
//   cfg_data      duration written to the table
//   timer_done    one-cycle phase-complete pulse (registered)
//   remaining     time units left in the current phase (registered)
//   busy          high while loading or counting (registered)
// -----------------------------------------------------------------------------
module wash_cycle_timer #(
    parameter int TICK_DIV    = 1000,
    parameter int CNT_W       = 12,
    parameter int DEFAULT_DUR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_enable,
    input  logic [1:0]       phase_sel,
    input  logic [1:0]       mode,
    input  logic             pause,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             timer_done,
    output logic [CNT_W-1:0] remaining,
    output logic             busy
);

    localparam int              PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PS_W-1:0]  r_presc;
    logic [PS_W-1:0]  w_presc_next;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] w_remain_next;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_next;

    logic [CNT_W-1:0] r_table [16];
    logic [CNT_W-1:0] w_load_val;

    logic             r_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_remain_out;

    // Duration table. Kept in flops rather than block RAM because every entry
    // must return to DEFAULT_DUR on reset. The LOAD read below is taken
    // combinationally from the current contents, so a write landing on the
    // same edge as the LOAD is not seen until the next LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_table[i] <= CNT_W'(DEFAULT_DUR);
            end
        end else if (cfg_we) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    assign w_load_val = r_table[{mode, phase_sel}];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_remain <= '0;
            r_phase  <= 2'd0;
        end else begin
            r_state  <= w_state_next;
            r_presc  <= w_presc_next;
            r_remain <= w_remain_next;
            r_phase  <= w_phase_next;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        w_state_next  = r_state;
        w_presc_next  = r_presc;
        w_remain_next = r_remain;
        w_phase_next  = r_phase;

        case (r_state)
            S_IDLE: begin
                w_presc_next  = '0;
                w_remain_next = '0;
                if (timer_enable) begin
                    w_state_next = S_LOAD;
                end
            end

            // LOAD always completes: enable and pause are not examined here.
            S_LOAD: begin
                w_remain_next = w_load_val;
                w_phase_next  = phase_sel;
                w_presc_next  = '0;
                w_state_next  = (w_load_val == '0) ? S_DONE : S_RUN;
            end

            S_RUN: begin
                if (!timer_enable) begin
                    w_state_next  = S_IDLE;
                    w_presc_next  = '0;
                    w_remain_next = '0;
                end else if (phase_sel != r_phase) begin
                    // Sequencer moved on: abandon this count silently.
                    w_state_next = S_LOAD;
                end else if (!pause) begin
                    if (r_presc == PS_LAST) begin
                        w_presc_next  = '0;
                        w_remain_next = r_remain - 1'b1;
                        if (r_remain == CNT_W'(1)) begin
                            w_state_next = S_DONE;
                        end
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (!timer_enable) begin
                    w_state_next  = S_IDLE;
                    w_presc_next  = '0;
                    w_remain_next = '0;
                end else begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                w_remain_next = '0;
                if (!timer_enable) begin
                    w_state_next = S_IDLE;
                    w_presc_next = '0;
                end else if (phase_sel != r_phase) begin
                    w_state_next = S_LOAD;
                end
            end

            default: begin
                w_state_next  = S_IDLE;
                w_presc_next  = '0;
                w_remain_next = '0;
            end
        endcase
    end

    // Outputs are registered copies of the internal state, so they trail the
    // state by one clock. The done pulse therefore appears in the cycle after
    // the FSM leaves DONE, and busy rises one cycle after LOAD is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_remain_out <= '0;
        end else begin
            r_done       <= (r_state == S_DONE);
            r_busy       <= (r_state == S_LOAD) || (r_state == S_RUN);
            r_remain_out <= r_remain;
        end
    end

    assign timer_done = r_done;
    assign busy       = r_busy;
    assign remaining  = r_remain_out;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_timer
//
// Directed bench for wash_cycle_timer with TICK_DIV=4. Inputs are driven and
// outputs sampled on the falling edge. Edge 0 is the rising edge that samples
// the start condition (enable in IDLE, or a phase change in WAIT); a phase of
// nonzero duration D shows timer_done after edge 2 + 4*D.
// -----------------------------------------------------------------------------
module tb_wash_cycle_timer;

    localparam int TICK  = 4;
    localparam int CW    = 12;
    localparam int DEFD  = 10;
    localparam int LIMIT = 2000;

    logic          clk;
    logic          rst_n;
    logic          timer_enable;
    logic [1:0]    phase_sel;
    logic [1:0]    mode;
    logic          pause;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          timer_done;
    logic [CW-1:0] remaining;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;
    int pulse_cnt = 0;

    wash_cycle_timer #(
        .TICK_DIV    (TICK),
        .CNT_W       (CW),
        .DEFAULT_DUR (DEFD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .timer_enable (timer_enable),
        .phase_sel    (phase_sel),
        .mode         (mode),
        .pause        (pause),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .timer_done   (timer_done),
        .remaining    (remaining),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timer_done === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [CW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        edges(1);
        cfg_we   = 1'b0;
    endtask

    // Steps edges from edge 0 until timer_done is seen. Optional events:
    // pause over edges [ps, ps+pl), a table write at edge wr_e, a mode change
    // applied before edge md_e. rem_lo/rem_hi span remaining over edges
    // ps+1 .. ps+pl; rem_max spans the whole run.
    task automatic time_phase(input int ps, input int pl,
                              input int wr_e, input logic [3:0] wr_a, input logic [CW-1:0] wr_d,
                              input int md_e, input logic [1:0] md_v,
                              output int done_edge, output int rem_lo, output int rem_hi,
                              output int rem_max);
        done_edge = -1;
        rem_lo    = 1 << 30;
        rem_hi    = -1;
        rem_max   = 0;
        for (int e = 0; e < LIMIT; e++) begin
            pause    = (e >= ps) && (e < ps + pl);
            cfg_we   = (e == wr_e);
            cfg_addr = wr_a;
            cfg_data = wr_d;
            if (e == md_e) mode = md_v;
            @(posedge clk);
            @(negedge clk);
            if (int'(remaining) > rem_max) rem_max = int'(remaining);
            if (e >= ps + 1 && e <= ps + pl) begin
                if (int'(remaining) < rem_lo) rem_lo = int'(remaining);
                if (int'(remaining) > rem_hi) rem_hi = int'(remaining);
            end
            if (timer_done === 1'b1) begin
                done_edge = e;
                break;
            end
        end
        pause  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic stop_timer();
        timer_enable = 1'b0;
        edges(2);
    endtask

    int de, lo, hi, mx, p0;
    int dur_seq [4] = '{2, 1, 3, 2};
    logic [CW-1:0] rem_a [17];
    logic          bsy_a [17];
    logic          dn_a  [17];

    initial begin
        rst_n = 1'b0; timer_enable = 1'b0; phase_sel = 2'd0; mode = 2'd0;
        pause = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = '0;
        edges(3);
        chk("reset_busy", busy, 0);
        chk("reset_done", timer_done, 0);
        chk("reset_remaining", remaining, 0);
        rst_n = 1'b1;
        edges(2);

        // Basic countdown, cycle-by-cycle trace: D=3 at {0,1}.
        cfg_write(4'd1, 12'd3);
        mode = 2'd0; phase_sel = 2'd1; timer_enable = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            @(posedge clk);
            @(negedge clk);
            rem_a[e] = remaining; bsy_a[e] = busy; dn_a[e] = timer_done;
        end
        chk("trace_busy_e0", bsy_a[0], 0);
        chk("trace_busy_e1", bsy_a[1], 1);
        chk("trace_rem_e2", rem_a[2], 3);
        chk("trace_rem_e5", rem_a[5], 3);
        chk("trace_rem_e6", rem_a[6], 2);
        chk("trace_rem_e9", rem_a[9], 2);
        chk("trace_rem_e10", rem_a[10], 1);
        chk("trace_rem_e13", rem_a[13], 1);
        chk("trace_rem_e14", rem_a[14], 0);
        chk("trace_busy_e13", bsy_a[13], 1);
        chk("trace_busy_e14", bsy_a[14], 0);
        chk("trace_done_e13", dn_a[13], 0);
        chk("trace_done_e14", dn_a[14], 1);
        chk("trace_done_e15", dn_a[15], 0);
        chk("trace_rem_wait", rem_a[16], 0);
        stop_timer();

        // Pause for 5 cycles mid-run: done delayed by exactly 5.
        timer_enable = 1'b1;
        time_phase(7, 5, -1, 4'd0, '0, -1, 2'd0, de, lo, hi, mx);
        chk("pause_done_edge", de, 2 + 3 * TICK + 5);
        chk("pause_rem_lo", lo, 2);
        chk("pause_rem_hi", hi, 2);
        edges(1);
        chk("pause_done_one_cycle", timer_done, 0);
        stop_timer();

        // Zero duration: LOAD straight to DONE.
        cfg_write(4'd11, 12'd0);
        mode = 2'd2; phase_sel = 2'd3; timer_enable = 1'b1;
        time_phase(LIMIT, 0, -1, 4'd0, '0, -1, 2'd0, de, lo, hi, mx);
        chk("zero_done_edge", de, 2);
        chk("zero_rem_max", mx, 0);
        stop_timer();

        // Full soak/wash/rinse/spin sequence in mode 1.
        for (int ph = 0; ph < 4; ph++) cfg_write(4'(4 + ph), 12'(dur_seq[ph]));
        mode = 2'd1; phase_sel = 2'd0; p0 = pulse_cnt;
        timer_enable = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            phase_sel = 2'(ph);
            time_phase(LIMIT, 0, -1, 4'd0, '0, -1, 2'd0, de, lo, hi, mx);
            chk($sformatf("seq_phase%0d_done_edge", ph), de, 2 + dur_seq[ph] * TICK);
        end
        edges(3);
        chk("seq_pulse_count", pulse_cnt - p0, 4);
        stop_timer();
        chk("seq_idle_busy", busy, 0);
        chk("seq_idle_remaining", remaining, 0);

        // Cancel mid-run: no pulse, back to IDLE.
        mode = 2'd3; phase_sel = 2'd0; timer_enable = 1'b1;
        edges(12);
        chk("cancel_busy_running", busy, 1);
        p0 = pulse_cnt;
        timer_enable = 1'b0;
        edges(2);
        chk("cancel_remaining", remaining, 0);
        chk("cancel_busy", busy, 0);
        edges(60);
        chk("cancel_no_pulse", pulse_cnt - p0, 0);

        // Asynchronous reset mid-run: table returns to DEFAULT_DUR.
        mode = 2'd1; phase_sel = 2'd1; timer_enable = 1'b1;
        edges(10);
        p0 = pulse_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_remaining", remaining, 0);
        timer_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edges(60);
        chk("rst_no_pulse", pulse_cnt - p0, 0);
        timer_enable = 1'b1;
        time_phase(LIMIT, 0, -1, 4'd0, '0, -1, 2'd0, de, lo, hi, mx);
        chk("rst_default_m1p1", de, 2 + DEFD * TICK);
        stop_timer();
        mode = 2'd0; phase_sel = 2'd1; timer_enable = 1'b1;
        time_phase(LIMIT, 0, -1, 4'd0, '0, -1, 2'd0, de, lo, hi, mx);
        chk("rst_default_m0p1", de, 2 + DEFD * TICK);
        stop_timer();

        // Table write to the active entry during RUN, plus a mode change.
        cfg_write(4'd1, 12'd3);
        mode = 2'd0; phase_sel = 2'd1; timer_enable = 1'b1;
        time_phase(LIMIT, 0, 5, 4'd1, 12'd5, 6, 2'd3, de, lo, hi, mx);
        chk("wr_run_keeps_old", de, 2 + 3 * TICK);
        stop_timer();
        // Next LOAD uses the new value; a write on the LOAD edge is not seen.
        mode = 2'd0; timer_enable = 1'b1;
        time_phase(LIMIT, 0, 1, 4'd1, 12'd7, -1, 2'd0, de, lo, hi, mx);
        chk("wr_next_load_new", de, 2 + 5 * TICK);
        stop_timer();
        timer_enable = 1'b1;
        time_phase(LIMIT, 0, -1, 4'd0, '0, -1, 2'd0, de, lo, hi, mx);
        chk("wr_load_edge_later", de, 2 + 7 * TICK);
        stop_timer();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
